escalonador_saida: RTL and testbench

Output-display scheduler for the processor's data-output stage. Two requesters share one set of output registers: the ALU monitor (operands plus result) and the OUT instruction path (result only). The block arbitrates between them round-robin, latches the winner's data into `saida_1`, `saida_2` and `saida_result`, and drives the matching `controle` code. It then holds the display for a programmable number of cycles so the external display stays readable before the next grant.

---
 rtl/escalonador_saida.sv | 127 ++++++++++++
 tb/tb_escalonador_saida.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_saida.sv
// Output display scheduler: round-robin arbitration between the ALU monitor and
// the OUT instruction path, latching the winner and holding the display a while.
module escalonador_saida #(
    parameter int HOLD_CYCLES = 4,
    parameter int WIDTH       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_alu,
    input  logic [WIDTH-1:0] alu_op1,
    input  logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             req_out,
    input  logic [WIDTH-1:0] out_dado,
    output logic             ack_alu,
    output logic             ack_out,
    output logic [1:0]       controle,
    output logic [WIDTH-1:0] saida_1,
    output logic [WIDTH-1:0] saida_2,
    output logic [WIDTH-1:0] saida_result,
    output logic             ocupado
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_last_alu;
    logic             w_last_alu_nxt;
    logic             r_ack_alu;
    logic             r_ack_out;
    logic             w_ack_alu_nxt;
    logic             w_ack_out_nxt;
    logic [1:0]       r_controle;
    logic [1:0]       w_controle_nxt;
    logic [WIDTH-1:0] r_saida_1;
    logic [WIDTH-1:0] r_saida_2;
    logic [WIDTH-1:0] r_saida_result;

    logic w_elig_alu;
    logic w_elig_out;
    logic w_slot;
    logic w_grant;
    logic w_win_alu;

    // A requester whose ack is currently high is masked so one request is never captured twice.
    assign w_elig_alu = req_alu & ~r_ack_alu;
    assign w_elig_out = req_out & ~r_ack_out;
    assign w_slot     = (r_state == ST_IDLE) || (r_cnt == '0);
    assign w_grant    = w_slot & (w_elig_alu | w_elig_out);
    assign w_win_alu  = w_elig_alu & (~w_elig_out | ~r_last_alu);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_alu_nxt = r_last_alu;
        w_ack_alu_nxt  = 1'b0;
        w_ack_out_nxt  = 1'b0;
        w_controle_nxt = r_controle;
        if (w_grant) begin
            w_state_nxt    = ST_HOLD;
            w_cnt_nxt      = CNT_LOAD;
            w_last_alu_nxt = w_win_alu;
            w_ack_alu_nxt  = w_win_alu;
            w_ack_out_nxt  = ~w_win_alu;
            w_controle_nxt = w_win_alu ? 2'b01 : 2'b10;
        end else if (r_state == ST_HOLD) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
                w_state_nxt    = ST_IDLE;
                w_controle_nxt = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last_alu <= 1'b0;
            r_ack_alu  <= 1'b0;
            r_ack_out  <= 1'b0;
            r_controle <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_alu <= w_last_alu_nxt;
            r_ack_alu  <= w_ack_alu_nxt;
            r_ack_out  <= w_ack_out_nxt;
            r_controle <= w_controle_nxt;
        end
    end

    // An OUT grant only touches the result; the operand displays keep the last ALU values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_saida_1      <= '0;
            r_saida_2      <= '0;
            r_saida_result <= '0;
        end else if (w_grant) begin
            if (w_win_alu) begin
                r_saida_1      <= alu_op1;
                r_saida_2      <= alu_op2;
                r_saida_result <= alu_result;
            end else begin
                r_saida_result <= out_dado;
            end
        end
    end

    assign ack_alu      = r_ack_alu;
    assign ack_out      = r_ack_out;
    assign controle     = r_controle;
    assign saida_1      = r_saida_1;
    assign saida_2      = r_saida_2;
    assign saida_result = r_saida_result;
    assign ocupado      = (r_state == ST_HOLD);

endmodule

// File: tb/tb_escalonador_saida.sv
// Bench for escalonador_saida: two instances (hold 4 and hold 1) driven by
// protocol-following requesters, scored against a grant-timeline model.
module tb_escalonador_saida;
    localparam int W = 32;

    typedef struct {
        bit             alu;
        logic [W-1:0]   e1;
        logic [W-1:0]   e2;
        logic [W-1:0]   er;
        int             edg;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         req_a [2];
    logic         req_o [2];
    logic [W-1:0] op1 [2];
    logic [W-1:0] op2 [2];
    logic [W-1:0] res [2];
    logic [W-1:0] dado [2];
    logic         ack_a [2];
    logic         ack_o [2];
    logic [1:0]   ctl [2];
    logic [W-1:0] s1 [2];
    logic [W-1:0] s2 [2];
    logic [W-1:0] sr [2];
    logic         ocup [2];

    // requester behaviour knobs: percent chance to raise an idle req, to re-request after an ack
    int  pr_a [2];
    int  pr_o [2];
    int  pk_a [2];
    int  pk_o [2];
    bit  ack_a_s [2];
    bit  ack_o_s [2];

    // reference model: grant timeline per instance
    int           edge_n;
    int           g_edge [2];
    bit           g_alu [2];
    bit           last_alu [2];
    logic [W-1:0] m1 [2];
    logic [W-1:0] m2 [2];
    logic [W-1:0] mr [2];
    txn_t         sbq0 [$];
    txn_t         sbq1 [$];

    int n_pass;
    int n_total;

    always #5 clk = ~clk;

    escalonador_saida #(.HOLD_CYCLES(4), .WIDTH(W)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_alu(req_a[0]), .alu_op1(op1[0]), .alu_op2(op2[0]), .alu_result(res[0]),
        .req_out(req_o[0]), .out_dado(dado[0]),
        .ack_alu(ack_a[0]), .ack_out(ack_o[0]), .controle(ctl[0]),
        .saida_1(s1[0]), .saida_2(s2[0]), .saida_result(sr[0]), .ocupado(ocup[0])
    );

    escalonador_saida #(.HOLD_CYCLES(1), .WIDTH(W)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_alu(req_a[1]), .alu_op1(op1[1]), .alu_op2(op2[1]), .alu_result(res[1]),
        .req_out(req_o[1]), .out_dado(dado[1]),
        .ack_alu(ack_a[1]), .ack_out(ack_o[1]), .controle(ctl[1]),
        .saida_1(s1[1]), .saida_2(s2[1]), .saida_result(sr[1]), .ocupado(ocup[1])
    );

    function automatic int hc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input int i, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %h expected %h (edge %0d)", name, i, got, exp, edge_n);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? sbq0.size() : sbq1.size();
    endfunction

    function automatic txn_t qfront(input int i);
        return (i == 0) ? sbq0[0] : sbq1[0];
    endfunction

    task automatic qpush(input int i, input txn_t t);
        if (i == 0) sbq0.push_back(t);
        else sbq1.push_back(t);
    endtask

    task automatic qpop(input int i, output txn_t t);
        if (i == 0) t = sbq0.pop_front();
        else t = sbq1.pop_front();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            g_edge[i]   = -100000;
            g_alu[i]    = 1'b0;
            last_alu[i] = 1'b0;
            m1[i] = '0;
            m2[i] = '0;
            mr[i] = '0;
            ack_a_s[i] = 1'b0;
            ack_o_s[i] = 1'b0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    // A grant may happen once HOLD_CYCLES edges have passed since the last grant;
    // the requester acked on the previous edge is ignored for this edge.
    task automatic model_edge(input int i);
        bit ea, eo, win;
        txn_t t;
        ea = req_a[i] && !(g_edge[i] == edge_n - 1 && g_alu[i]);
        eo = req_o[i] && !(g_edge[i] == edge_n - 1 && !g_alu[i]);
        if ((edge_n - g_edge[i]) >= hc(i) && (ea || eo)) begin
            win = ea && (!eo || !last_alu[i]);
            if (win) begin
                m1[i] = op1[i];
                m2[i] = op2[i];
                mr[i] = res[i];
            end else begin
                mr[i] = dado[i];
            end
            g_edge[i]   = edge_n;
            g_alu[i]    = win;
            last_alu[i] = win;
            t.alu = win;
            t.e1  = m1[i];
            t.e2  = m2[i];
            t.er  = mr[i];
            t.edg = edge_n;
            qpush(i, t);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            edge_n++;
            for (int i = 0; i < 2; i++) model_edge(i);
        end
    end

    task automatic monitor_inst(input int i);
        txn_t t;
        bit eoc;
        logic [1:0] ec;
        chk("ack_excl", i, ack_a[i] & ack_o[i], 1'b0);
        if (ack_a[i] || ack_o[i]) begin
            if (qsize(i) == 0) begin
                chk("unexpected_ack", i, {ack_a[i], ack_o[i]}, 2'b00);
            end else begin
                qpop(i, t);
                chk("ack_data", i, {ack_a[i], ack_o[i], s1[i], s2[i], sr[i]},
                    {t.alu, !t.alu, t.e1, t.e2, t.er});
                chk("ack_edge", i, edge_n, t.edg);
            end
        end else if (qsize(i) > 0 && qfront(i).edg <= edge_n) begin
            qpop(i, t);
            chk("missing_ack", i, {ack_a[i], ack_o[i]}, {t.alu, !t.alu});
        end
        eoc = (edge_n - g_edge[i]) < hc(i);
        ec  = eoc ? (g_alu[i] ? 2'b01 : 2'b10) : 2'b00;
        chk("ctl_ocup", i, {ctl[i], ocup[i]}, {ec, eoc});
        chk("display", i, {s1[i], s2[i], sr[i]}, {m1[i], m2[i], mr[i]});
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ack_a_s[i] = ack_a[i];
            ack_o_s[i] = ack_o[i];
        end
        if (rst_n) begin
            for (int i = 0; i < 2; i++) monitor_inst(i);
        end
    end

    task automatic check_zero(input string name);
        for (int i = 0; i < 2; i++)
            chk(name, i, {ack_a[i], ack_o[i], ctl[i], ocup[i], s1[i], s2[i], sr[i]}, '0);
    endtask

    // Requesters: hold req until the ack is sampled, then drop or re-request with new data.
    task automatic cycle_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (req_a[i] && ack_a_s[i]) begin
                if ($urandom_range(0, 99) < pk_a[i]) begin
                    op1[i] = op1[i] + 1;
                    op2[i] = op2[i] + 2;
                    res[i] = res[i] + 3;
                end else begin
                    req_a[i] = 1'b0;
                end
            end else if (!req_a[i] && $urandom_range(0, 99) < pr_a[i]) begin
                req_a[i] = 1'b1;
                op1[i] = $urandom;
                op2[i] = $urandom;
                res[i] = $urandom;
            end
            if (req_o[i] && ack_o_s[i]) begin
                if ($urandom_range(0, 99) < pk_o[i]) dado[i] = dado[i] + 1;
                else req_o[i] = 1'b0;
            end else if (!req_o[i] && $urandom_range(0, 99) < pr_o[i]) begin
                req_o[i] = 1'b1;
                dado[i] = $urandom;
            end
        end
    endtask

    task automatic set_knobs(input int pra, input int pro, input int pka, input int pko);
        for (int i = 0; i < 2; i++) begin
            pr_a[i] = pra;
            pr_o[i] = pro;
            pk_a[i] = pka;
            pk_o[i] = pko;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        edge_n  = 0;
        model_reset();
        set_knobs(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 1'b0;
            req_o[i] = 1'b0;
            dado[i]  = '0;
        end
        // reset with a pending ALU request and non-zero data
        req_a[0] = 1'b1; op1[0] = 5; op2[0] = 3; res[0] = 8;
        req_a[1] = 1'b1; op1[1] = 1; op2[1] = 2; res[1] = 3;
        #3;
        check_zero("rst_outputs");
        repeat (3) @(posedge clk);
        #2;
        check_zero("rst_outputs_clocked");
        rst_n = 1'b1;
        repeat (8) cycle_step();

        // single OUT request after the ALU display
        req_o[0] = 1'b1; dado[0] = 32'h2A;
        repeat (8) cycle_step();

        // simultaneous requests, both re-requesting after each ack
        set_knobs(0, 0, 100, 100);
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 1'b1; op1[i] = 32'h100; op2[i] = 32'h200; res[i] = 32'h300;
            req_o[i] = 1'b1; dado[i] = 32'h400;
        end
        repeat (14) cycle_step();
        set_knobs(0, 0, 0, 0);
        repeat (12) cycle_step();

        // continuous ALU request on the hold-1 instance
        pk_a[1] = 100;
        req_a[1] = 1'b1; op1[1] = 32'h10; op2[1] = 32'h20; res[1] = 32'h30;
        repeat (10) cycle_step();
        pk_a[1] = 0;
        repeat (4) cycle_step();

        // reset while the hold-4 display is mid-window (counter at 2)
        req_a[0] = 1'b1; op1[0] = 32'hA1; op2[0] = 32'hA2; res[0] = 32'hA3;
        cycle_step();
        cycle_step();
        req_o[0] = 1'b1; dado[0] = 32'h77;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rst_mid_hold");
        #4;
        rst_n = 1'b1;
        repeat (8) cycle_step();

        // random traffic
        set_knobs(25, 25, 50, 50);
        repeat (3000) cycle_step();
        set_knobs(0, 0, 0, 0);
        repeat (20) cycle_step();
        for (int i = 0; i < 2; i++) chk("sb_drained", i, qsize(i), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
